ex_stage_pipe: RTL and testbench

Parametrised, registered execute stage for the MIPS-DLX pipeline: operand forwarding, ALU-source and destination-register selection, ALU control decode, ALU, and the EX/MEM latch in one block. It adds a valid/ready handshake, synchronous flush, and an optional iterative multiplier that stalls the upstream decode stage. It sits between the ID/EX latch and the memory stage.

---
 rtl/ex_stage_pipe_pkg.sv | 66 ++++++
 rtl/ex_stage_pipe_mult_seq.sv | 69 ++++++
 rtl/ex_stage_pipe.sv | 180 ++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// ex_pkg: shared encodings for the MIPS-DLX execute stage (ALU control,
// funct codes, alu_op, forwarding selects, FSM states) plus the ALU decoder.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_BUS     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_BUS_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  // Map alu_op/funct to an ALU operation; MULT only exists when mult_en is set
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct,
                                           input logic       mult_en);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_SLT:  ctrl = ALU_SLT;
          FUNCT_MULT: ctrl = mult_en ? ALU_MUL : ALU_ADD;
          default:    ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_mult_seq.sv
// ex_mult_seq: iterative shift-add multiplier, one bit per cycle, DATA_W
// iterations; done_o pulses for one cycle with the low DATA_W product bits.
// Only compiled when EX_MULT_EN is defined.
`ifdef EX_MULT_EN
module ex_mult_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q;

  // Capture operands on start, then add-and-shift once per cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule
`endif

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered MIPS-DLX execute stage with forwarding, ALU
// decode, ALU and EX/MEM latch behind a valid/ready handshake.
// Optional EX_MULT_EN: funct 0x18 becomes a multi-cycle MULT that stalls
// in_ready via the ex_mult_seq sub-module.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ex_control,
  input  logic [3:0]        mem_control_in,
  input  logic [1:0]        wb_control_in,
  input  logic [DATA_W-1:0] busa,
  input  logic [DATA_W-1:0] busb,
  input  logic [DATA_W-1:0] immed_ext,
  input  logic [31:0]       instruc,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic [DATA_W-1:0] data_write,
  output logic [RA_W-1:0]   wb_register,
  output logic [3:0]        mem_control_out,
  output logic [1:0]        wb_control_out
);

`ifdef EX_MULT_EN
  localparam logic MULT_EN = 1'b1;
`else
  localparam logic MULT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [RA_W-1:0]   dest_reg;
  alu_ctrl_e         alu_ctrl;
  logic              accept;

  logic              out_valid_q, zero_q;
  logic [DATA_W-1:0] alu_out_q, data_write_q;
  logic [RA_W-1:0]   wb_register_q;
  logic [3:0]        mem_control_q;
  logic [1:0]        wb_control_q;

  // Forwarding, ALU-source select, destination select and ALU decode
  always_comb begin
    case (fwd_a_sel)
      FWD_MEM: fwd_a = fwd_mem_data;
      FWD_WB:  fwd_a = fwd_wb_data;
      default: fwd_a = busa;
    endcase
    case (fwd_b_sel)
      FWD_MEM: fwd_b = fwd_mem_data;
      FWD_WB:  fwd_b = fwd_wb_data;
      default: fwd_b = busb;
    endcase
    alu_b    = ex_control[2] ? immed_ext : fwd_b;
    dest_reg = ex_control[3] ? RA_W'(instruc[15:11]) : RA_W'(instruc[20:16]);
    alu_ctrl = alu_decode(ex_control[1:0], instruc[5:0], MULT_EN);
  end

  // Single-cycle ALU; arithmetic wraps modulo 2^DATA_W
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_res = fwd_a + alu_b;
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      default: alu_res = fwd_a + alu_b;
    endcase
  end

`ifdef EX_MULT_EN
  ex_state_e         state_q;
  logic              is_mult, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign is_mult  = (alu_ctrl == ALU_MUL);
  assign in_ready = !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);

  ex_mult_seq #(.DATA_W(DATA_W)) u_mult (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .clear_i   (flush),
    .start_i   (accept && is_mult),
    .a_i       (fwd_a),
    .b_i       (alu_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`else
  assign in_ready = !flush && (!out_valid_q || out_ready);
`endif

  assign accept = in_valid && in_ready;

  // FSM and EX/MEM latch: load on accept, hold under backpressure, kill on flush.
  // A MULT writes its side-band fields (data_write, wb_register, controls)
  // at accept time with out_valid low, so only the result waits for done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      alu_out_q     <= '0;
      zero_q        <= 1'b0;
      data_write_q  <= '0;
      wb_register_q <= '0;
      mem_control_q <= '0;
      wb_control_q  <= '0;
`ifdef EX_MULT_EN
      state_q       <= ST_IDLE;
`endif
    end else if (flush) begin
      out_valid_q   <= 1'b0;
      alu_out_q     <= '0;
      zero_q        <= 1'b0;
      data_write_q  <= '0;
      wb_register_q <= '0;
      mem_control_q <= '0;
      wb_control_q  <= '0;
`ifdef EX_MULT_EN
      state_q       <= ST_IDLE;
`endif
    end else if (accept) begin
      data_write_q  <= fwd_b;
      wb_register_q <= dest_reg;
      mem_control_q <= mem_control_in;
      wb_control_q  <= wb_control_in;
`ifdef EX_MULT_EN
      if (is_mult) begin
        out_valid_q <= 1'b0;
        state_q     <= ST_MUL;
      end else
`endif
      begin
        alu_out_q   <= alu_res;
        zero_q      <= (alu_res == '0);
        out_valid_q <= 1'b1;
      end
    end
`ifdef EX_MULT_EN
    else if (mul_done) begin
      alu_out_q   <= mul_prod;
      zero_q      <= (mul_prod == '0);
      out_valid_q <= 1'b1;
      state_q     <= ST_IDLE;
    end
`endif
    else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid       = out_valid_q;
  assign alu_out         = alu_out_q;
  assign zero            = zero_q;
  assign data_write      = data_write_q;
  assign wb_register     = wb_register_q;
  assign mem_control_out = mem_control_q;
  assign wb_control_out  = wb_control_q;

  // rs, shamt and opcode fields are not used by this stage
  logic unused_ok;
`ifdef EX_MULT_EN
  assign unused_ok = ^{instruc[31:21], instruc[10:6], mul_busy};
`else
  assign unused_ok = ^{instruc[31:21], instruc[10:6]};
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe (scoreboard of expected latch contents).
module tb_ex_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef EX_MULT_EN
  localparam logic [31:0] MUL_EXP = 32'hFFFF_FFFF;
  localparam int          MUL_LAT = DW + 1;
`else
  localparam logic [31:0] MUL_EXP = 32'h0002_0000;
  localparam int          MUL_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    ex_control = '0;
  logic [3:0]    mem_control_in = '0;
  logic [1:0]    wb_control_in = '0;
  logic [DW-1:0] busa = '0, busb = '0, immed_ext = '0;
  logic [31:0]   instruc = '0;
  logic [1:0]    fwd_a_sel = '0, fwd_b_sel = '0;
  logic [DW-1:0] fwd_mem_data = '0, fwd_wb_data = '0;

  logic          in_ready, out_valid, zero;
  logic [DW-1:0] alu_out, data_write;
  logic [AW-1:0] wb_register;
  logic [3:0]    mem_control_out;
  logic [1:0]    wb_control_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] alu;
    logic        z;
    logic [31:0] dw;
    logic [4:0]  wr;
    logic [3:0]  mc;
    logic [1:0]  wc;
  } exp_t;

  exp_t sb[$];

  logic [75:0] dut_bus;
  assign dut_bus = {alu_out, zero, data_write, wb_register, mem_control_out, wb_control_out};

  ex_stage_pipe #(.DATA_W(DW), .RA_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .ex_control      (ex_control),
    .mem_control_in  (mem_control_in),
    .wb_control_in   (wb_control_in),
    .busa            (busa),
    .busb            (busb),
    .immed_ext       (immed_ext),
    .instruc         (instruc),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .fwd_mem_data    (fwd_mem_data),
    .fwd_wb_data     (fwd_wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_out         (alu_out),
    .zero            (zero),
    .data_write      (data_write),
    .wb_register     (wb_register),
    .mem_control_out (mem_control_out),
    .wb_control_out  (wb_control_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [75:0] pack_exp(input exp_t e);
    return {e.alu, e.z, e.dw, e.wr, e.mc, e.wc};
  endfunction

  // Reference model of the latch contents for the inputs currently driven
  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, b, op2, r;
    a = (fwd_a_sel == 2'b01) ? fwd_mem_data : (fwd_a_sel == 2'b10) ? fwd_wb_data : busa;
    b = (fwd_b_sel == 2'b01) ? fwd_mem_data : (fwd_b_sel == 2'b10) ? fwd_wb_data : busb;
    op2 = ex_control[2] ? immed_ext : b;
    case (ex_control[1:0])
      2'b00: r = a + op2;
      2'b01: r = a - op2;
      2'b11: r = a | op2;
      default: begin
        case (instruc[5:0])
          6'h22: r = a - op2;
          6'h24: r = a & op2;
          6'h25: r = a | op2;
          6'h2A: r = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
`ifdef EX_MULT_EN
          6'h18: r = a * op2;
`endif
          default: r = a + op2;
        endcase
      end
    endcase
    e.alu = r;
    e.z   = (r == 32'd0);
    e.dw  = b;
    e.wr  = ex_control[3] ? instruc[15:11] : instruc[20:16];
    e.mc  = mem_control_in;
    e.wc  = wb_control_in;
    return e;
  endfunction

  task automatic set_op(input logic [3:0] exc, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [4:0] rt, input logic [4:0] rd);
    ex_control     = exc;
    instruc        = {6'h00, 5'd1, rt, rd, 5'd0, funct};
    busa           = a;
    busb           = b;
    immed_ext      = imm;
    fwd_a_sel      = fa;
    fwd_b_sel      = fb;
    fwd_mem_data   = $urandom;
    fwd_wb_data    = $urandom;
    mem_control_in = 4'($urandom_range(1, 15));
    wb_control_in  = 2'($urandom_range(1, 3));
  endtask

  // Push expectation, present the op until accepted (bounded), drop in_valid after the edge
  task automatic send(output bit ok);
    sb.push_back(model());
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!ok) void'(sb.pop_back());
  endtask

  task automatic wait_out(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i <= budget; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, dut_bus} !== 77'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {out_valid, dut_bus});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    // reset while a result is held under backpressure
    out_ready = 1'b0;
    set_op(4'b0000, 6'h20, 32'd5, 32'd6, 32'd0, 2'b00, 2'b00, 5'd2, 5'd3);
    send(ok);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_valid: got %b required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, dut_bus} !== 77'd0) begin
      n_fail++;
      $display("FAIL reset_held_clear: got %h required 0", {out_valid, dut_bus});
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready/out_valid %b required 10", {in_ready, out_valid});
    end
`ifdef EX_MULT_EN
    // reset in the middle of a multiply discards it
    set_op(4'b1010, 6'h18, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'b00, 2'b00, 5'd4, 5'd5);
    send(ok);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, dut_bus} !== 77'd0) begin
      n_fail++;
      $display("FAIL reset_mult_clear: got %h required 0", {out_valid, dut_bus});
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (DW + 5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mult_discard: got stray_valid=%b in_ready=%b required 0/1", seen, in_ready);
    end
`else
    seen = 1'b0;
`endif
    drain();
  endtask

  task automatic test_alu_ops();
    bit ok;
    int cyc;
    exp_t e;
    logic [3:0]  t_exc[9]   = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0011, 4'b0110};
    logic [5:0]  t_fn[9]    = '{6'h22, 6'h24, 6'h25, 6'h20, 6'h2A, 6'h3F, 6'h20, 6'h20, 6'h20};
    logic [31:0] t_a[9]     = '{32'd10, 32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'd5, 32'd100, 32'd3, 32'h1200_0000, 32'hFFFF_FFF0};
    logic [31:0] t_b[9]     = '{32'd3, 32'h0000_FF00, 32'h0000_FF00, 32'd2, 32'hFFFF_FFFF, 32'd23, 32'd3, 32'h0000_0034, 32'd7};
    // SLT: -1 < 1 signed
    set_op(4'b1010, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 2'b00, 5'd3, 5'd7);
    send(ok);
    wait_out(3, ok, cyc);
    n_checks++;
    if (!ok || {alu_out, zero, wb_register} !== {32'd1, 1'b0, 5'd7}) begin
      n_fail++;
      $display("FAIL rtype_slt: got valid=%b alu=%h zero=%b wr=%0d required alu=1 zero=0 wr=7",
               out_valid, alu_out, zero, wb_register);
    end
    e = sb.pop_front();
    n_checks++;
    if (dut_bus !== pack_exp(e)) begin
      n_fail++;
      $display("FAIL rtype_slt_latch: got %h required %h", dut_bus, pack_exp(e));
    end
    for (int i = 0; i < 9; i++) begin
      set_op(t_exc[i], t_fn[i], t_a[i], t_b[i], 32'h0000_0100, 2'b00, 2'b00, 5'(i + 8), 5'(i + 20));
      send(ok);
      wait_out(3, ok, cyc);
      e = sb.pop_front();
      n_checks++;
      if (!ok || cyc != 0 || dut_bus !== pack_exp(e)) begin
        n_fail++;
        $display("FAIL alu_op_%0d: got valid=%b cyc=%0d bus=%h required valid=1 cyc=0 bus=%h",
                 i, out_valid, cyc, dut_bus, pack_exp(e));
      end
    end
    drain();
  endtask

  task automatic test_forwarding();
    bit ok;
    int cyc;
    exp_t e;
    set_op(4'b0100, 6'h00, 32'h0000_0777, 32'h0000_ABCD, 32'h10, 2'b01, 2'b00, 5'd9, 5'd4);
    fwd_mem_data = 32'h20;
    send(ok);
    wait_out(3, ok, cyc);
    n_checks++;
    if (!ok || {alu_out, wb_register, data_write} !== {32'h30, 5'd9, 32'h0000_ABCD}) begin
      n_fail++;
      $display("FAIL fwd_itype: got alu=%h wr=%0d dw=%h required alu=30 wr=9 dw=0000abcd",
               alu_out, wb_register, data_write);
    end
    void'(sb.pop_front());
    for (int fa = 0; fa < 4; fa++) begin
      for (int fb = 0; fb < 4; fb++) begin
        set_op(4'b1001, 6'h00, $urandom, $urandom, $urandom, 2'(fa), 2'(fb), 5'(fa), 5'(fb + 16));
        send(ok);
        wait_out(3, ok, cyc);
        e = sb.pop_front();
        n_checks++;
        if (!ok || dut_bus !== pack_exp(e)) begin
          n_fail++;
          $display("FAIL fwd_sel_%0d%0d: got %h required %h", fa, fb, dut_bus, pack_exp(e));
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    exp_t e;
    out_ready = 1'b0;
    set_op(4'b1010, 6'h25, 32'h1234_0000, 32'h0000_5678, 32'd0, 2'b00, 2'b00, 5'd6, 5'd12);
    send(ok);
    e = sb[0];
    repeat (3) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_bus !== pack_exp(e)) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b in_ready=%b bus=%h required 1/0 bus=%h",
                 out_valid, in_ready, dut_bus, pack_exp(e));
      end
      @(posedge clk);
      #1;
    end
    set_op(4'b1010, 6'h22, 32'd50, 32'd8, 32'd0, 2'b00, 2'b00, 5'd1, 5'd2);
    sb.push_back(model());
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_rise: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    void'(sb.pop_front());
    wait_out(0, ok, cyc);
    e = sb.pop_front();
    n_checks++;
    if (!ok || dut_bus !== pack_exp(e)) begin
      n_fail++;
      $display("FAIL bp_next: got valid=%b bus=%h required valid=1 bus=%h", out_valid, dut_bus, pack_exp(e));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        set_op({1'b1, 1'b0, 2'b10}, fns[i], $urandom, $urandom, 32'd0, 2'(i % 3), 2'((i + 1) % 3), 5'(i), 5'(i + 10));
        sb.push_back(model());
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dut_bus !== pack_exp(e)) begin
          n_fail++;
          $display("FAIL b2b_out_%0d: got valid=%b bus=%h required valid=1 bus=%h",
                   i - 1, out_valid, dut_bus, pack_exp(e));
        end
      end
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
  endtask

  task automatic test_mult();
    bit ok;
    bit low_ok;
    int cyc;
    exp_t e;
    set_op(4'b1010, 6'h18, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'b00, 2'b00, 5'd11, 5'd13);
    send(ok);
    low_ok = 1'b1;
    cyc = -1;
    for (int i = 0; i <= DW + 10; i++) begin
      if (out_valid) begin
        cyc = i;
        break;
      end
      if (in_ready !== 1'b0) low_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cyc != MUL_LAT) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d required %0d", cyc, MUL_LAT);
    end
    n_checks++;
    if (alu_out !== MUL_EXP || wb_register !== 5'd13) begin
      n_fail++;
      $display("FAIL mult_result: got alu=%h wr=%0d required alu=%h wr=13", alu_out, wb_register, MUL_EXP);
    end
`ifdef EX_MULT_EN
    n_checks++;
    if (!low_ok) begin
      n_fail++;
      $display("FAIL mult_in_ready: got high during multiply required low");
    end
`endif
    void'(sb.pop_front());
    set_op(4'b1010, 6'h18, 32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 2'b10, 2'b01, 5'd7, 5'd8);
    send(ok);
    wait_out(DW + 10, ok, cyc);
    e = sb.pop_front();
    n_checks++;
    if (!ok || dut_bus !== pack_exp(e)) begin
      n_fail++;
      $display("FAIL mult_fwd: got valid=%b bus=%h required valid=1 bus=%h", out_valid, dut_bus, pack_exp(e));
    end
    drain();
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    int cyc;
    exp_t e;
`ifdef EX_MULT_EN
    set_op(4'b1010, 6'h18, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'b00, 2'b00, 5'd4, 5'd5);
    send(ok);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_mult_idle: got valid/in_ready %b required 01", {out_valid, in_ready});
    end
    sb.delete();
    seen = 1'b0;
    repeat (DW + 5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_mult_discard: got stray out_valid required none");
    end
`else
    seen = 1'b0;
`endif
    // flush kills a held result and beats a simultaneous accept
    out_ready = 1'b0;
    set_op(4'b0000, 6'h00, 32'd1, 32'd2, 32'd0, 2'b00, 2'b00, 5'd1, 5'd1);
    send(ok);
    set_op(4'b0000, 6'h00, 32'd7, 32'd8, 32'd0, 2'b00, 2'b00, 5'd2, 5'd2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready_low: got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_accept: got %b required 0", out_valid);
    end
    sb.delete();
    set_op(4'b0000, 6'h00, 32'h0000_1000, 32'h0000_0234, 32'd0, 2'b00, 2'b00, 5'd17, 5'd18);
    send(ok);
    wait_out(3, ok, cyc);
    e = sb.pop_front();
    n_checks++;
    if (!ok || alu_out !== 32'h0000_1234 || dut_bus !== pack_exp(e)) begin
      n_fail++;
      $display("FAIL flush_then_add: got valid=%b bus=%h required valid=1 bus=%h", out_valid, dut_bus, pack_exp(e));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_backpressure();
    test_back_to_back();
    test_mult();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
